// File: rtl/logic_unit_pkg.sv
// Shared op codes, FSM states and the extended-op list for logic_unit_seq.
// The extended ops are enabled by defining LOGIC_UNIT_EXT_OPS_EN.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NOTA  = 3'b011,
    OP_NAND  = 3'b100,
    OP_NOR   = 3'b101,
    OP_XNOR  = 3'b110,
    OP_PASSA = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int NUM_EXT_OPS = 4;
  localparam op_e EXT_OPS [NUM_EXT_OPS] = '{OP_NAND, OP_NOR, OP_XNOR, OP_PASSA};

  function automatic logic is_ext_op(input logic [2:0] op);
    is_ext_op = 1'b0;
    for (int i = 0; i < NUM_EXT_OPS; i++) begin
      if (op == EXT_OPS[i]) is_ext_op = 1'b1;
    end
  endfunction

endpackage

// File: rtl/logic_unit_seq_slice.sv
// logic_slice: combinational SLICE-wide bitwise operation selected by op.
// Extended ops exist only when LOGIC_UNIT_EXT_OPS_EN is defined.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [2:0]       i_op,
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  output logic [SLICE-1:0] o_y,
  output logic             o_unsup
);

  always_comb begin
    o_y     = '0;
    o_unsup = 1'b0;
    case (op_e'(i_op))
      OP_AND:   o_y = i_a & i_b;
      OP_OR:    o_y = i_a | i_b;
      OP_XOR:   o_y = i_a ^ i_b;
      OP_NOTA:  o_y = ~i_a;
`ifdef LOGIC_UNIT_EXT_OPS_EN
      OP_NAND:  o_y = ~(i_a & i_b);
      OP_NOR:   o_y = ~(i_a | i_b);
      OP_XNOR:  o_y = ~(i_a ^ i_b);
      OP_PASSA: o_y = i_a;
`endif
      // Unsupported ops yield a zero slice and flag the error.
      default:  o_unsup = is_ext_op(i_op);
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: bit-serial (SLICE bits/cycle) logic unit with valid/ready handshakes.
// Ops 1xx are supported only when LOGIC_UNIT_EXT_OPS_EN is defined.
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_f;
  logic             r_zero;
  logic             r_err;

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE-1:0] w_y_slice;
  logic             w_unsup;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_a_slice = r_a[int'(r_k)*SLICE +: SLICE];
  assign w_b_slice = r_b[int'(r_k)*SLICE +: SLICE];
  assign w_last    = (r_k == K_LAST);

  logic_slice #(.SLICE(SLICE)) u_slice (
    .i_op    (r_op),
    .i_a     (w_a_slice),
    .i_b     (w_b_slice),
    .o_y     (w_y_slice),
    .o_unsup (w_unsup)
  );

  // Slices build up in r_acc so f only ever shows a complete result.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[int'(r_k)*SLICE +: SLICE] = w_y_slice;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_BUSY;
      S_BUSY:  if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_acc   <= '0;
      r_f     <= '0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_k   <= '0;
            r_acc <= '0;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 1'b1;
          if (w_last) begin
            r_f    <= w_acc_next;
            r_zero <= (w_acc_next == '0);
            r_err  <= w_unsup;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign f         = r_f;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq at WIDTH=8, SLICE=4: vector table,
// hand-written corner sequences and randomized traffic against a word-level model.
module tb_logic_unit_seq;

  localparam int W = 8;
  localparam int S = 4;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] f;
  logic         zero;
  logic         err;
  logic         out_valid;
  logic         out_ready;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] f;
    logic         z;
    logic         e;
  } vec_t;

  vec_t vecs[$];

  logic_unit_seq #(.WIDTH(W), .SLICE(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .f         (f),
    .zero      (zero),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Whole-word reference: the result is the op applied to the full operands.
  function automatic void refModel(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] r, output logic z, output logic e);
    e = 1'b0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: r = x ^ y;
      3'b011: r = ~x;
`ifdef LOGIC_UNIT_EXT_OPS_EN
      3'b100: r = ~(x & y);
      3'b101: r = ~(x | y);
      3'b110: r = ~(x ^ y);
      default: r = x;
`else
      default: begin r = '0; e = 1'b1; end
`endif
    endcase
    z = (r == '0);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] opI, input logic [W-1:0] aI,
                               input logic [W-1:0] bI, input logic [W-1:0] expF, input logic expZ,
                               input logic expE, input int hold, input bit disturb);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    checkOutput({tag, " in_ready before request"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    op = opI;
    a  = aI;
    b  = bI;
    tick();
    in_valid = disturb;
    if (disturb) begin
      op = 3'($urandom_range(7, 0));
      a  = W'($urandom);
      b  = W'($urandom);
      out_ready = 1'b1;
    end
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
      out_ready = 1'b0;
      if (disturb) begin
        op = 3'($urandom_range(7, 0));
        a  = W'($urandom);
        b  = W'($urandom);
      end
    end
    in_valid = 1'b0;
    checkOutput({tag, " latency"}, 64'(cyc), 64'(N));
    checkOutput({tag, " f"}, 64'(f), 64'(expF));
    checkOutput({tag, " zero"}, 64'(zero), 64'(expZ));
    checkOutput({tag, " err"}, 64'(err), 64'(expE));
    checkOutput({tag, " in_ready in DONE"}, 64'(in_ready), 64'(0));
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput({tag, " hold out_valid"}, 64'(out_valid), 64'(1));
      checkOutput({tag, " hold f"}, 64'(f), 64'(expF));
      checkOutput({tag, " hold in_ready"}, 64'(in_ready), 64'(0));
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput({tag, " out_valid after release"}, 64'(out_valid), 64'(0));
    checkOutput({tag, " in_ready after release"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [W-1:0] rf;
    logic         rz;
    logic         re;
    logic [2:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           cyc;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("reset in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset f", 64'(f), 64'(0));
    checkOutput("reset zero", 64'(zero), 64'(0));
    checkOutput("reset err", 64'(err), 64'(0));

    vecs.push_back('{op: 3'b000, a: 8'hF0, b: 8'h3C, f: 8'h30, z: 1'b0, e: 1'b0});
    vecs.push_back('{op: 3'b011, a: 8'hFF, b: 8'h12, f: 8'h00, z: 1'b1, e: 1'b0});
    vecs.push_back('{op: 3'b001, a: 8'h0F, b: 8'hF0, f: 8'hFF, z: 1'b0, e: 1'b0});
    vecs.push_back('{op: 3'b010, a: 8'hAA, b: 8'hAA, f: 8'h00, z: 1'b1, e: 1'b0});
    vecs.push_back('{op: 3'b010, a: 8'hA5, b: 8'h0F, f: 8'hAA, z: 1'b0, e: 1'b0});
    vecs.push_back('{op: 3'b000, a: 8'h00, b: 8'hFF, f: 8'h00, z: 1'b1, e: 1'b0});
    vecs.push_back('{op: 3'b011, a: 8'h5A, b: 8'hFF, f: 8'hA5, z: 1'b0, e: 1'b0});
`ifdef LOGIC_UNIT_EXT_OPS_EN
    vecs.push_back('{op: 3'b101, a: 8'h0F, b: 8'hF0, f: 8'h00, z: 1'b1, e: 1'b0});
    vecs.push_back('{op: 3'b111, a: 8'h5A, b: 8'h00, f: 8'h5A, z: 1'b0, e: 1'b0});
    vecs.push_back('{op: 3'b100, a: 8'hF0, b: 8'h3C, f: 8'hCF, z: 1'b0, e: 1'b0});
`else
    vecs.push_back('{op: 3'b101, a: 8'h0F, b: 8'hF0, f: 8'h00, z: 1'b1, e: 1'b1});
    vecs.push_back('{op: 3'b111, a: 8'h5A, b: 8'h00, f: 8'h00, z: 1'b1, e: 1'b1});
    vecs.push_back('{op: 3'b100, a: 8'hF0, b: 8'h3C, f: 8'h00, z: 1'b1, e: 1'b1});
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].f, vecs[i].z, vecs[i].e, 0, 1'b0);
    end

    applyStimulus("hold5", 3'b001, 8'h81, 8'h18, 8'h99, 1'b0, 1'b0, 5, 1'b0);
    applyStimulus("disturb", 3'b010, 8'hC3, 8'h5A, 8'h99, 1'b0, 1'b0, 1, 1'b1);

    // Reset pulsed mid-operation: nothing from the dropped request may surface.
    in_valid = 1'b1;
    op = 3'b000;
    a = 8'hFF;
    b = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("busy reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("busy reset f", 64'(f), 64'(0));
    checkOutput("busy reset zero", 64'(zero), 64'(0));
    checkOutput("busy reset in_ready", 64'(in_ready), 64'(1));
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) cyc++;
    end
    checkOutput("busy reset no stale out_valid", 64'(cyc), 64'(0));

    for (int t = 0; t < 40; t++) begin
      ro = 3'($urandom_range(7, 0));
      ra = W'($urandom);
      rb = W'($urandom);
      refModel(ro, ra, rb, rf, rz, re);
      applyStimulus($sformatf("rand%0d op%0d", t, ro), ro, ra, rb, rf, rz, re,
                    $urandom_range(3, 0), bit'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
